fsic_axil_cfg_initiator: RTL and testbench

AXI-Lite configuration initiator that drives the register port of IO serdes and other FSIC config slaves. It accepts single-beat read/write requests from the local config sequencer, performs the AXI-Lite handshakes and asserts the slave enable for the duration of the access. It returns read data or a timeout error. This config interface has no B channel: a write completes when both the AW and W handshakes have occurred.

---
 rtl/fsic_cfg_pkg.sv | 19 +
 rtl/fsic_axil_cfg_initiator.sv | 175 +++++++++++++++++
 tb/tb_fsic_axil_cfg_initiator.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fsic_cfg_pkg.sv
// Shared types and constants for the FSIC config interface.
// Used by the AXI-Lite config initiator and its slaves.
package fsic_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD_A = 3'd2,
    RD_D = 3'd3,
    RESP = 3'd4
  } cfg_state_e;

  localparam int P_TIMEOUT_DEF = 255;

  localparam logic [11:0] IOSERDES_REG_OFS = 12'h000;
  localparam int IOSERDES_RXEN_BIT = 0;
  localparam int IOSERDES_TXEN_BIT = 1;

endpackage

// File: rtl/fsic_axil_cfg_initiator.sv
// AXI-Lite config initiator: single-beat reads/writes with timeout.
// Writes complete on AW+W handshakes; there is no B channel.
module fsic_axil_cfg_initiator
  import fsic_cfg_pkg::*;
#(
  parameter int pADDR_WIDTH = 15,
  parameter int pDATA_WIDTH = 32,
  parameter int pTIMEOUT    = P_TIMEOUT_DEF
) (
  input  logic                     axi_clk,
  input  logic                     axi_reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [pADDR_WIDTH-1:0]   req_addr,
  input  logic [pDATA_WIDTH-1:0]   req_wdata,
  input  logic [pDATA_WIDTH/8-1:0] req_wstrb,
  output logic                     rsp_valid,
  output logic [pDATA_WIDTH-1:0]   rsp_rdata,
  output logic                     rsp_err,
  output logic                     cc_enable,
  output logic                     axi_awvalid,
  output logic [pADDR_WIDTH-1:0]   axi_awaddr,
  input  logic                     axi_awready,
  output logic                     axi_wvalid,
  output logic [pDATA_WIDTH-1:0]   axi_wdata,
  output logic [pDATA_WIDTH/8-1:0] axi_wstrb,
  input  logic                     axi_wready,
  output logic                     axi_arvalid,
  output logic [pADDR_WIDTH-1:0]   axi_araddr,
  input  logic                     axi_arready,
  input  logic                     axi_rvalid,
  input  logic [pDATA_WIDTH-1:0]   axi_rdata,
  output logic                     axi_rready
);

  localparam int SW = pDATA_WIDTH / 8;
  localparam logic [7:0] TMO_LAST = 8'(pTIMEOUT - 1);

  cfg_state_e state_q, state_d;

  logic                   aw_done_q, aw_done_d;
  logic                   w_done_q, w_done_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [pADDR_WIDTH-1:0] addr_q, addr_d;
  logic [pDATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [SW-1:0]          wstrb_q, wstrb_d;
  logic                   err_d;
  logic                   tmo_hit;

  logic req_ready_q, rsp_valid_q, rsp_err_q;
  logic cc_enable_q;
  logic awvalid_q, wvalid_q, arvalid_q, rready_q;

  assign tmo_hit = (cnt_q == TMO_LAST);

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = rsp_err_q;
  assign cc_enable   = cc_enable_q;
  assign axi_awvalid = awvalid_q;
  assign axi_awaddr  = addr_q;
  assign axi_wvalid  = wvalid_q;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = wstrb_q;
  assign axi_arvalid = arvalid_q;
  assign axi_araddr  = addr_q;
  assign axi_rready  = rready_q;

  // Next state, handshake tracking, timeout and capture
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    cnt_d     = cnt_q + 8'd1;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_valid && req_ready_q) begin
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          wstrb_d   = req_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = req_write ? WR : RD_A;
        end
      end
      WR: begin
        aw_done_d = aw_done_q | (awvalid_q & axi_awready);
        w_done_d  = w_done_q | (wvalid_q & axi_wready);
        if (aw_done_d && w_done_d) begin
          state_d = RESP;
        end else if (tmo_hit) begin
          state_d = RESP;
          err_d   = 1'b1;
        end
      end
      RD_A: begin
        if (arvalid_q && axi_arready) begin
          state_d = RD_D;
          cnt_d   = '0;
        end else if (tmo_hit) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      RD_D: begin
        if (axi_rvalid && rready_q) begin
          state_d = RESP;
          rdata_d = axi_rdata;
        end else if (tmo_hit) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      RESP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs, all derived from the next state
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state_q     <= IDLE;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      cc_enable_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rdata_q     <= rdata_d;
      req_ready_q <= (state_d == IDLE);
      rsp_valid_q <= (state_d == RESP);
      rsp_err_q   <= err_d;
      cc_enable_q <= (state_d inside {WR, RD_A, RD_D});
      awvalid_q   <= (state_d == WR) && !aw_done_d;
      wvalid_q    <= (state_d == WR) && !w_done_d;
      arvalid_q   <= (state_d == RD_A);
      rready_q    <= (state_d == RD_D);
    end
  end

endmodule

// File: tb/tb_fsic_axil_cfg_initiator.sv
// Scoreboard bench for the AXI-Lite config initiator.
// Stub slave with stall modes; monitor checks each response.
module tb_fsic_axil_cfg_initiator;
  import fsic_cfg_pkg::*;

  logic        axi_clk = 1'b0;
  logic        axi_reset_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [14:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        cc_enable;
  logic        axi_awvalid;
  logic [14:0] axi_awaddr;
  logic        axi_awready;
  logic        axi_wvalid;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wready;
  logic        axi_arvalid;
  logic [14:0] axi_araddr;
  logic        axi_arready;
  logic        axi_rvalid;
  logic [31:0] axi_rdata;
  logic        axi_rready;

  always #5 axi_clk = ~axi_clk;

  fsic_axil_cfg_initiator dut (
    .axi_clk     (axi_clk),
    .axi_reset_n (axi_reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_wstrb   (req_wstrb),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .cc_enable   (cc_enable),
    .axi_awvalid (axi_awvalid),
    .axi_awaddr  (axi_awaddr),
    .axi_awready (axi_awready),
    .axi_wvalid  (axi_wvalid),
    .axi_wdata   (axi_wdata),
    .axi_wstrb   (axi_wstrb),
    .axi_wready  (axi_wready),
    .axi_arvalid (axi_arvalid),
    .axi_araddr  (axi_araddr),
    .axi_arready (axi_arready),
    .axi_rvalid  (axi_rvalid),
    .axi_rdata   (axi_rdata),
    .axi_rready  (axi_rready)
  );

  typedef struct {
    bit          rd;
    logic [31:0] rdata;
    bit          err;
    int          lat;
    int          aw_c;
    int          w_c;
    int          ar_c;
    int          rr_c;
    int          hs;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // stub slave state and controls
  logic [31:0] mem [2];
  bit          hold = 0;
  int          aw_delay = 0;
  bit          no_ar = 0;
  int          aw_hs_n = 0;
  int          w_hs_n = 0;
  int          ar_hs_n = 0;
  logic [14:0] last_awaddr = '0;
  logic [14:0] last_araddr = '0;
  bit          aw_got, w_got, r_pend, r_hs;
  int          since_w;
  logic [14:0] aw_a, ar_a;
  logic [31:0] wd;
  logic [3:0]  ws;

  // monitor state
  int mon_cyc = 0;
  int acc_cyc = 0;
  int last_gap = 0;
  int aw_c, w_c, ar_c, rr_c;
  int awh0, wh0, arh0;
  bit in_tx = 0;

  function automatic exp_t mk(bit rd, logic [31:0] rdata, bit err,
                              int lat, int aw, int w, int ar,
                              int rr, int hs);
    exp_t e;
    e.rd = rd; e.rdata = rdata; e.err = err; e.lat = lat;
    e.aw_c = aw; e.w_c = w; e.ar_c = ar; e.rr_c = rr; e.hs = hs;
    return e;
  endfunction

  function automatic int sidx(logic [14:0] a);
    return (a[11:2] == IOSERDES_REG_OFS[11:2]) ? 0 : 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // slave: readies decided at negedge for the coming posedge
  initial begin
    axi_awready = 0; axi_wready = 0; axi_arready = 0;
    axi_rvalid = 0; axi_rdata = '0;
    mem[0] = '0; mem[1] = '0;
    aw_got = 0; w_got = 0; r_pend = 0; r_hs = 0; since_w = 0;
    aw_a = '0; ar_a = '0; wd = '0; ws = '0;
    forever begin
      @(negedge axi_clk);
      if (!axi_reset_n) begin
        axi_awready = 0; axi_wready = 0; axi_arready = 0;
        axi_rvalid = 0;
        aw_got = 0; w_got = 0; r_pend = 0; r_hs = 0;
      end else begin
        if (r_hs) begin axi_rvalid = 0; r_hs = 0; end
        if (r_pend) begin
          axi_rvalid = 1; axi_rdata = mem[sidx(ar_a)]; r_pend = 0;
        end
        if (w_got) since_w++;
        axi_awready = axi_awvalid && !hold &&
                      (aw_delay == 0 || (w_got && since_w >= aw_delay));
        axi_wready  = axi_wvalid && !hold;
        axi_arready = axi_arvalid && !hold && !no_ar;
        if (axi_awvalid && axi_awready) begin
          aw_hs_n++; aw_got = 1; aw_a = axi_awaddr;
          last_awaddr = axi_awaddr;
        end
        if (axi_wvalid && axi_wready) begin
          w_hs_n++; w_got = 1; since_w = 0;
          wd = axi_wdata; ws = axi_wstrb;
        end
        if (aw_got && w_got) begin
          for (int b = 0; b < 4; b++)
            if (ws[b]) mem[sidx(aw_a)][8*b +: 8] = wd[8*b +: 8];
          aw_got = 0; w_got = 0;
        end
        if (axi_arvalid && axi_arready) begin
          ar_hs_n++; r_pend = 1; ar_a = axi_araddr;
          last_araddr = axi_araddr;
        end
        if (axi_rvalid && axi_rready) r_hs = 1;
      end
    end
  end

  // monitor: pops an expectation on every rsp_valid
  initial begin
    exp_t e;
    aw_c = 0; w_c = 0; ar_c = 0; rr_c = 0;
    awh0 = 0; wh0 = 0; arh0 = 0;
    forever begin
      @(negedge axi_clk);
      mon_cyc++;
      if (!axi_reset_n) begin
        in_tx = 0;
        continue;
      end
      if (in_tx) begin
        aw_c += int'(axi_awvalid);
        w_c  += int'(axi_wvalid);
        ar_c += int'(axi_arvalid);
        rr_c += int'(axi_rready);
      end
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected none");
        end else begin
          e = sb.pop_front();
          chk("rsp_err", rsp_err, e.err);
          chk("latency", mon_cyc - acc_cyc, e.lat);
          if (e.rd) begin
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("arvalid_cycles", ar_c, e.ar_c);
            chk("rready_cycles", rr_c, e.rr_c);
            chk("ar_handshakes", ar_hs_n - arh0, e.hs);
          end else begin
            chk("awvalid_cycles", aw_c, e.aw_c);
            chk("wvalid_cycles", w_c, e.w_c);
            chk("aw_handshakes", aw_hs_n - awh0, e.hs);
            chk("w_handshakes", w_hs_n - wh0, e.hs);
          end
        end
        in_tx = 0;
      end
      if (req_valid && req_ready) begin
        last_gap = mon_cyc - acc_cyc;
        acc_cyc  = mon_cyc;
        in_tx = 1;
        aw_c = 0; w_c = 0; ar_c = 0; rr_c = 0;
        awh0 = aw_hs_n; wh0 = w_hs_n; arh0 = ar_hs_n;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge axi_clk);
    #1;
  endtask

  // called just after a posedge; returns just after acceptance edge
  task automatic send(input bit wr, input logic [14:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input bit push, input exp_t e, input bit keep);
    int n = 0;
    req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
    req_valid = 1;
    if (push) sb.push_back(e);
    @(negedge axi_clk);
    while (!req_ready && n < 50) begin
      @(negedge axi_clk);
      n++;
    end
    chk("req_accept", req_ready, 1'b1);
    if (!req_ready) begin
      req_valid = 0;
      if (push) void'(sb.pop_back());
    end else begin
      @(posedge axi_clk);
      #1;
      if (!keep) req_valid = 0;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge axi_clk);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t nil;
    nil = mk(0, '0, 0, 0, 0, 0, 0, 0, 0);
    #1 axi_reset_n = 0;
    repeat (3) @(negedge axi_clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cc_enable", cc_enable, 0);
    chk("rst_awvalid", axi_awvalid, 0);
    chk("rst_arvalid", axi_arvalid, 0);
    chk("rst_rready", axi_rready, 0);
    chk("rst_rdata", rsp_rdata, 0);
    axi_reset_n = 1;
    @(negedge axi_clk);
    chk("post_rst_req_ready", req_ready, 1);
    idle(1);

    // 1: zero-wait write enabling rx and tx
    send(1, 15'h000, 32'h0000_0003, 4'hF, 1,
         mk(0, '0, 0, 2, 1, 1, 0, 0, 1), 0);
    drain(20);
    chk("t1_rxen", mem[0][IOSERDES_RXEN_BIT], 1);
    chk("t1_txen", mem[0][IOSERDES_TXEN_BIT], 1);
    idle(1);

    // 2: zero-wait read back
    send(0, 15'h000, '0, '0, 1,
         mk(1, 32'h0000_0003, 0, 3, 0, 0, 1, 1, 1), 0);
    drain(20);
    idle(1);

    // 3: awready two cycles after the W handshake, byte 0 only
    aw_delay = 2;
    send(1, 15'h000, 32'hA5A5_0001, 4'b0001, 1,
         mk(0, '0, 0, 4, 3, 1, 0, 0, 1), 0);
    drain(20);
    aw_delay = 0;
    chk("t3_mem", mem[0], 32'h0000_0001);
    idle(1);

    // 4: arready never comes -> timeout, then a normal read
    no_ar = 1;
    send(0, 15'h000, '0, '0, 1,
         mk(1, 32'h0, 1, 256, 0, 0, 255, 0, 0), 0);
    drain(400);
    no_ar = 0;
    idle(1);
    send(0, 15'h000, '0, '0, 1,
         mk(1, 32'h0000_0001, 0, 3, 0, 0, 1, 1, 1), 0);
    drain(20);
    idle(1);

    // 5: reset while a write is stalled
    hold = 1;
    send(1, 15'h000, 32'hFFFF_FFFF, 4'hF, 0, nil, 0);
    repeat (3) @(negedge axi_clk);
    chk("t5_awvalid_before", axi_awvalid, 1);
    chk("t5_cc_enable_before", cc_enable, 1);
    axi_reset_n = 0;
    #1;
    chk("t5_awvalid", axi_awvalid, 0);
    chk("t5_wvalid", axi_wvalid, 0);
    chk("t5_cc_enable", cc_enable, 0);
    chk("t5_req_ready", req_ready, 0);
    repeat (2) @(negedge axi_clk);
    axi_reset_n = 1;
    hold = 0;
    repeat (2) @(negedge axi_clk);
    chk("t5_req_ready_after", req_ready, 1);
    chk("t5_mem_untouched", mem[0], 32'h0000_0001);
    idle(3);

    // 6: back-to-back with req_valid held, non-serdes address
    send(1, 15'h1004, 32'h0000_0002, 4'hF, 1,
         mk(0, '0, 0, 2, 1, 1, 0, 0, 1), 1);
    send(0, 15'h1004, '0, '0, 1,
         mk(1, 32'h0000_0002, 0, 3, 0, 0, 1, 1, 1), 0);
    drain(20);
    chk("t6_accept_gap", last_gap, 3);
    chk("t6_awaddr", last_awaddr, 15'h1004);
    chk("t6_araddr", last_araddr, 15'h1004);
    chk("t6_serdes_untouched", mem[0], 32'h0000_0001);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
